data_sram_arb: RTL and testbench
================================

Name: data_sram_arb

Overview:
- Shares the single-port 64-bit data SRAM between the pipeline LSU (EX-stage issue, read data captured by MEM1 one cycle later) and a debug/DMA requester.
- The pipeline has fixed priority. A wait counter guarantees the debug port a slot after MAX_WAIT blocked cycles.
- When debug wins a slot while the pipeline is requesting, the block raises a combinational stall request; the pipeline re-issues its access.

Parameters:
- MAX_WAIT, 4, debug cycles blocked before a forced debug grant; legal range 1..15.
- AW, 32, address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pipe_en  in  1  pipeline SRAM access valid (EX stage)
- pipe_we  in  8  pipeline byte write enables; 0 = read
- pipe_addr  in  AW  pipeline address
- pipe_wdata  in  64  pipeline write data
- pipe_stall_req  out  1  pipeline access rejected this cycle; stall EX and re-issue
- dbg_req  in  1  debug access request, held until dbg_gnt
- dbg_we  in  8  debug byte write enables; 0 = read
- dbg_addr  in  AW  debug address
- dbg_wdata  in  64  debug write data
- dbg_gnt  out  1  debug access issued to SRAM this cycle
- dbg_rvalid  out  1  dbg_rdata valid (one-cycle pulse)
- dbg_rdata  out  64  debug read data, held until next debug read returns
- conflict_cnt  out  16  saturating count of forced grants
- data_sram_en  out  1  SRAM enable
- data_sram_we  out  8  SRAM byte write enables
- data_sram_addr  out  AW  SRAM address
- data_sram_wdata  out  64  SRAM write data
- data_sram_rdata  in  64  SRAM read data, one cycle after a read enable

Behaviour:
- Reset (async, rst_n=0):
  - wait_cnt=0, rd_owner=0, rd_pend=0.
  - dbg_rvalid=0, dbg_rdata=0, conflict_cnt=0.
  - Combinational outputs follow their inputs; there is no reset-time SRAM access beyond what the inputs drive.
- Grant (combinational, same cycle):
  - force = (wait_cnt == MAX_WAIT).
  - dbg_gnt = dbg_req & (~pipe_en | force).
  - pipe_grant = pipe_en & ~dbg_gnt.
  - pipe_stall_req = pipe_en & dbg_gnt.
- SRAM mux:
  - If dbg_gnt, drive the dbg_* fields with en=1.
  - Else if pipe_en, drive the pipe_* fields with en=1.
  - Else drive en=0, we=0, addr/wdata=0.
- wait_cnt (registered):
  - Reset to 0 when dbg_gnt or ~dbg_req.
  - Increment when dbg_req & pipe_en & ~dbg_gnt.
  - Never exceeds MAX_WAIT.
  - After a forced grant the counter is 0, so the pipeline gets at least one unblocked cycle before the next forced grant.
- Read tracking:
  - rd_pend <= dbg_gnt & (dbg_we==0).
  - In the cycle after a debug read grant, data_sram_rdata belongs to debug. The pipeline is stalled in that slot, so MEM1 captures don't-care data.
- Debug return:
  - When rd_pend, on the next edge dbg_rdata <= data_sram_rdata and dbg_rvalid <= 1; otherwise dbg_rvalid <= 0.
  - Total read latency is grant cycle N to dbg_rvalid in cycle N+2.
  - Debug writes complete at grant and produce no rvalid.
- conflict_cnt: increments when dbg_gnt & pipe_en (a forced grant); saturates at 0xFFFF.
- Back-to-back debug reads (pipeline idle): one grant per cycle, with rvalid pulses in consecutive cycles.
- pipe_en and dbg_req both low: SRAM idle; counters hold.
- Reset mid-read: the pending read is dropped and no rvalid pulse follows.
- dbg_req dropped before grant is a protocol violation; the counter clears and no access occurs.

Decomposition:
- Shared package/define file:
  - data SRAM width constants (DATA_W=64, WE_W=8).
  - Default MAX_WAIT.
- Sub-module sat_cnt16: a 16-bit saturating counter with enable, used for conflict_cnt.
- All other logic stays in data_sram_arb.

Test Plan:
- Pipeline only: pipe_en=1, pipe_we=0, addr 0x100 for 5 cycles.
  - Required: data_sram_en=1 with addr 0x100 every cycle, pipe_stall_req=0, dbg_gnt=0.
- Debug read, pipeline idle: dbg_req=1, dbg_we=0, addr 0x40 at cycle N; SRAM returns 0xDEADBEEF_CAFEF00D at N+1.
  - Required: dbg_gnt=1 at N, dbg_rvalid=1 and dbg_rdata=0xDEADBEEFCAFEF00D at N+2, pipe_stall_req=0.
- Starvation with MAX_WAIT=4: pipe_en=1 continuously, dbg_req=1 from cycle 0.
  - Required: dbg_gnt=0 for cycles 0-3.
  - Required at cycle 4: dbg_gnt=1 and pipe_stall_req=1, conflict_cnt becomes 1.
  - Required at cycle 5: pipeline granted.
- Debug write under contention: dbg_we=0xFF, wdata 0x1122334455667788, with a forced grant.
  - Required: the SRAM sees we=0xFF with that data in the grant cycle and no dbg_rvalid follows.
- Reset mid-operation: assert rst_n=0 in cycle N+1 after a debug read grant.
  - Required: dbg_rvalid stays 0, dbg_rdata=0, wait_cnt=0, conflict_cnt=0 immediately (asynchronously).
- Saturation: force 65537 conflicts.
  - Required: conflict_cnt=0xFFFF and it does not wrap.

Source files
------------

// File: rtl/data_sram_arb_pkg.sv
// Shared constants for the data SRAM arbiter and its helpers.
package data_sram_arb_pkg;

    localparam int unsigned DATA_W           = 64;
    localparam int unsigned WE_W             = 8;
    localparam int unsigned AW_DEFAULT       = 32;
    localparam int unsigned CNT_W            = 16;
    localparam int unsigned WAIT_W           = 4;
    localparam int unsigned MAX_WAIT_DEFAULT = 4;

endpackage : data_sram_arb_pkg

// File: rtl/data_sram_arb_sat_cnt16.sv
// 16-bit saturating up-counter with enable.
module sat_cnt16
    import data_sram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count up on enable, stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : sat_cnt16

// File: rtl/data_sram_arb.sv
// Single-port data SRAM arbiter: pipeline LSU has priority, debug/DMA port
// gets a forced slot after MAX_WAIT blocked cycles.
module data_sram_arb
    import data_sram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned AW       = AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              pipe_en,
    input  logic [WE_W-1:0]   pipe_we,
    input  logic [AW-1:0]     pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall_req,

    input  logic              dbg_req,
    input  logic [WE_W-1:0]   dbg_we,
    input  logic [AW-1:0]     dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [CNT_W-1:0]  conflict_cnt,

    output logic              data_sram_en,
    output logic [WE_W-1:0]   data_sram_we,
    output logic [AW-1:0]     data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    logic [WAIT_W-1:0] wait_cnt;
    logic              force_gnt;
    logic              pipe_grant;
    logic              rd_pend;

    // Same-cycle grant: debug wins when the pipeline is idle or it has waited long enough.
    always_comb begin
        force_gnt      = (wait_cnt == WAIT_W'(MAX_WAIT));
        dbg_gnt        = dbg_req & (~pipe_en | force_gnt);
        pipe_grant     = pipe_en & ~dbg_gnt;
        pipe_stall_req = pipe_en & dbg_gnt;
    end

    // SRAM request mux; idle cycles drive zeros so the bus is quiet.
    always_comb begin
        data_sram_en    = 1'b0;
        data_sram_we    = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        if (dbg_gnt) begin
            data_sram_en    = 1'b1;
            data_sram_we    = dbg_we;
            data_sram_addr  = dbg_addr;
            data_sram_wdata = dbg_wdata;
        end else if (pipe_grant) begin
            data_sram_en    = 1'b1;
            data_sram_we    = pipe_we;
            data_sram_addr  = pipe_addr;
            data_sram_wdata = pipe_wdata;
        end
    end

    // Blocked-cycle counter; cleared on grant so the pipeline always gets a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (pipe_en && !force_gnt) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Remember a debug read so the following rdata beat is routed to debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= dbg_gnt & (dbg_we == '0);
        end
    end

    // Debug read return: capture rdata and pulse rvalid; rdata holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= rd_pend;
            if (rd_pend) begin
                dbg_rdata <= data_sram_rdata;
            end
        end
    end

    // Count grants that bumped a live pipeline access.
    sat_cnt16 u_conflict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dbg_gnt & pipe_en),
        .cnt   (conflict_cnt)
    );

endmodule : data_sram_arb

// File: tb/tb_data_sram_arb.sv
// Directed self-checking bench for data_sram_arb.
module tb_data_sram_arb;

    localparam int unsigned AW = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_en;
    logic [7:0]  pipe_we;
    logic [31:0] pipe_addr;
    logic [63:0] pipe_wdata;
    logic        pipe_stall_req;
    logic        dbg_req;
    logic [7:0]  dbg_we;
    logic [31:0] dbg_addr;
    logic [63:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [63:0] dbg_rdata;
    logic [15:0] conflict_cnt;
    logic        data_sram_en;
    logic [7:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [63:0] data_sram_wdata;
    logic [63:0] data_sram_rdata;
    logic        sat_en;
    logic [15:0] sat_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_sram_arb #(.MAX_WAIT(4), .AW(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pipe_en         (pipe_en),
        .pipe_we         (pipe_we),
        .pipe_addr       (pipe_addr),
        .pipe_wdata      (pipe_wdata),
        .pipe_stall_req  (pipe_stall_req),
        .dbg_req         (dbg_req),
        .dbg_we          (dbg_we),
        .dbg_addr        (dbg_addr),
        .dbg_wdata       (dbg_wdata),
        .dbg_gnt         (dbg_gnt),
        .dbg_rvalid      (dbg_rvalid),
        .dbg_rdata       (dbg_rdata),
        .conflict_cnt    (conflict_cnt),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata)
    );

    sat_cnt16 u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sat_en),
        .cnt   (sat_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the start of the next cycle (just after the rising edge).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        pipe_en         = 1'b0;
        pipe_we         = '0;
        pipe_addr       = '0;
        pipe_wdata      = '0;
        dbg_req         = 1'b0;
        dbg_we          = '0;
        dbg_addr        = '0;
        dbg_wdata       = '0;
        data_sram_rdata = '0;
        sat_en          = 1'b0;

        #1;
        check("rst_rvalid", 64'(dbg_rvalid), 64'd0);
        check("rst_rdata", dbg_rdata, 64'd0);
        check("rst_conflict", 64'(conflict_cnt), 64'd0);
        check("rst_sram_en", 64'(data_sram_en), 64'd0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;

        // Pipeline only, read at 0x100 for five cycles.
        pipe_en   = 1'b1;
        pipe_addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("pipe_en", 64'(data_sram_en), 64'd1);
            check("pipe_addr", 64'(data_sram_addr), 64'h100);
            check("pipe_stall", 64'(pipe_stall_req), 64'd0);
            check("pipe_gnt", 64'(dbg_gnt), 64'd0);
            next_cycle();
        end

        // Both idle: SRAM quiet.
        pipe_en = 1'b0;
        @(negedge clk);
        check("idle_en", 64'(data_sram_en), 64'd0);
        check("idle_addr", 64'(data_sram_addr), 64'd0);
        next_cycle();

        // Debug read with pipeline idle: grant at N, rvalid at N+2.
        dbg_req  = 1'b1;
        dbg_we   = '0;
        dbg_addr = 32'h40;
        @(negedge clk);
        check("dr_gnt", 64'(dbg_gnt), 64'd1);
        check("dr_addr", 64'(data_sram_addr), 64'h40);
        check("dr_stall", 64'(pipe_stall_req), 64'd0);
        next_cycle();
        dbg_req         = 1'b0;
        data_sram_rdata = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        check("dr_rvalid_n1", 64'(dbg_rvalid), 64'd0);
        next_cycle();
        data_sram_rdata = '0;
        @(negedge clk);
        check("dr_rvalid_n2", 64'(dbg_rvalid), 64'd1);
        check("dr_rdata", dbg_rdata, 64'hDEADBEEF_CAFEF00D);
        next_cycle();
        @(negedge clk);
        check("dr_rvalid_n3", 64'(dbg_rvalid), 64'd0);
        check("dr_rdata_hold", dbg_rdata, 64'hDEADBEEF_CAFEF00D);
        next_cycle();

        // Starvation: debug read blocked four cycles, forced at cycle 4.
        pipe_en   = 1'b1;
        pipe_addr = 32'h200;
        dbg_req   = 1'b1;
        dbg_addr  = 32'h80;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("st_gnt_c%0d", c), 64'(dbg_gnt), (c == 4) ? 64'd1 : 64'd0);
            check($sformatf("st_stall_c%0d", c), 64'(pipe_stall_req), (c == 4) ? 64'd1 : 64'd0);
            check($sformatf("st_addr_c%0d", c), 64'(data_sram_addr), (c == 4) ? 64'h80 : 64'h200);
            check($sformatf("st_conf_c%0d", c), 64'(conflict_cnt), 64'd0);
            next_cycle();
        end
        dbg_req         = 1'b0;
        data_sram_rdata = 64'h01234567_89ABCDEF;
        @(negedge clk);
        check("st_c5_gnt", 64'(dbg_gnt), 64'd0);
        check("st_c5_stall", 64'(pipe_stall_req), 64'd0);
        check("st_c5_addr", 64'(data_sram_addr), 64'h200);
        check("st_c5_conf", 64'(conflict_cnt), 64'd1);
        next_cycle();
        data_sram_rdata = '0;
        @(negedge clk);
        check("st_rvalid", 64'(dbg_rvalid), 64'd1);
        check("st_rdata", dbg_rdata, 64'h01234567_89ABCDEF);
        next_cycle();

        // Debug write under contention: forced after four blocked cycles.
        dbg_req   = 1'b1;
        dbg_we    = 8'hFF;
        dbg_addr  = 32'hC0;
        dbg_wdata = 64'h11223344_55667788;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("dw_gnt_c%0d", c), 64'(dbg_gnt), (c == 4) ? 64'd1 : 64'd0);
            if (c == 4) begin
                check("dw_we", 64'(data_sram_we), 64'hFF);
                check("dw_wdata", data_sram_wdata, 64'h11223344_55667788);
                check("dw_addr", 64'(data_sram_addr), 64'hC0);
            end
            next_cycle();
        end
        dbg_req = 1'b0;
        dbg_we  = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("dw_no_rvalid_%0d", c), 64'(dbg_rvalid), 64'd0);
            next_cycle();
        end
        check("dw_conf", 64'(conflict_cnt), 64'd2);

        // Both low: counters hold.
        pipe_en = 1'b0;
        next_cycle();
        @(negedge clk);
        check("hold_conf", 64'(conflict_cnt), 64'd2);
        check("hold_rdata", dbg_rdata, 64'h01234567_89ABCDEF);
        next_cycle();

        // Reset mid-read: grant at N, reset during N+1.
        dbg_req  = 1'b1;
        dbg_addr = 32'h48;
        @(negedge clk);
        check("mr_gnt", 64'(dbg_gnt), 64'd1);
        next_cycle();
        dbg_req         = 1'b0;
        data_sram_rdata = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rvalid", 64'(dbg_rvalid), 64'd0);
        check("mr_rdata", dbg_rdata, 64'd0);
        check("mr_conf", 64'(conflict_cnt), 64'd0);
        check("mr_wait", 64'(dut.wait_cnt), 64'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("mr_post_rvalid_%0d", c), 64'(dbg_rvalid), 64'd0);
            next_cycle();
        end
        data_sram_rdata = '0;

        // Saturation: 65537 increments on the conflict counter cell.
        sat_en = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 64'(sat_cnt), 64'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_ffff", 64'(sat_cnt), 64'hFFFF);
        sat_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_data_sram_arb
